// File: rtl/operand_fetch_pkg.sv
// Shared widths and the operand bundle handed from operand fetch to execute.
package operand_fetch_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int OP_W    = 4;
    localparam int NREGS   = 16;
    localparam int STALL_W = 16;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } of_bundle_t;

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy scoreboard: one bit per register with a write outstanding.
// eff_busy already excludes a register being written back this cycle, so a
// waiting consumer can issue in the writeback cycle using the forwarded value.
module reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              flush_clr,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic [NREGS-1:0]  busy,
    output logic [NREGS-1:0]  eff_busy
);

    logic [NREGS-1:0] busy_q, busy_d, wb_clr;

    // Writeback clear mask and the hazard view seen by the current instruction
    always_comb begin
        wb_clr = '0;
        if (wb_we) wb_clr[wb_addr] = 1'b1;
        eff_busy = busy_q & ~wb_clr;
    end

    // Next busy vector: writeback and flush clears first, issue set last so it wins
    always_comb begin
        busy_d = eff_busy;
        if (flush_clr) busy_d[flush_addr] = 1'b0;
        if (set_en)    busy_d[set_addr]   = 1'b1;
    end

    // Busy register
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, forwards a same-cycle writeback,
// stalls on RAW/WAW hazards and holds one operand bundle for execute.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [ADDR_W-1:0]  in_rs1,
    input  logic [ADDR_W-1:0]  in_rs2,
    input  logic [ADDR_W-1:0]  in_rd,
    input  logic               in_wr,
    output logic [ADDR_W-1:0]  r_addr1,
    output logic [ADDR_W-1:0]  r_addr2,
    input  logic [DATA_W-1:0]  r_data1,
    input  logic [DATA_W-1:0]  r_data2,
    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic [ADDR_W-1:0]  out_rd,
    output logic               out_wr,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [STALL_W-1:0] stall_cnt
);

    of_bundle_t         out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [NREGS-1:0]   busy, eff_busy;
    logic [DATA_W-1:0]  fwd_a, fwd_b;
    logic               hazard, issue, flush_clr;

    assign r_addr1 = in_rs1;
    assign r_addr2 = in_rs2;

    // Register-file write lands on the edge, so bypass it for same-cycle reads
    always_comb begin
        fwd_a = (wb_we && wb_addr == in_rs1) ? wb_data : r_data1;
        fwd_b = (wb_we && wb_addr == in_rs2) ? wb_data : r_data2;
    end

    // Hazard check and handshake; in_ready follows out_ready combinationally
    always_comb begin
        hazard    = eff_busy[in_rs1] || eff_busy[in_rs2] || (in_wr && eff_busy[in_rd]);
        in_ready  = !rst && !flush && !hazard && (!out_valid_q || out_ready);
        issue     = in_valid && in_ready;
        flush_clr = flush && out_valid_q && out_q.wr;
    end

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en     (issue && in_wr),
        .set_addr   (in_rd),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .flush_clr  (flush_clr),
        .flush_addr (out_q.rd),
        .busy       (busy),
        .eff_busy   (eff_busy)
    );

    // Output register, valid and saturating stall counter next-state
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_d.op    = in_op;
            out_d.rd    = in_rd;
            out_d.wr    = in_wr;
            out_d.a     = fwd_a;
            out_d.b     = fwd_b;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && !in_ready && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_q.op;
    assign out_rd    = out_q.rd;
    assign out_wr    = out_q.wr;
    assign out_a     = out_q.a;
    assign out_b     = out_q.b;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wr;
    logic [3:0]  in_op, in_rs1, in_rs2, in_rd;
    logic [3:0]  r_addr1, r_addr2;
    logic [15:0] r_data1, r_data2;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush, out_valid, out_ready, out_wr;
    logic [3:0]  out_op, out_rd;
    logic [15:0] out_a, out_b, stall_cnt;
    logic [15:0] regs [16];

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .r_data1(r_data1), .r_data2(r_data2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_wr(out_wr),
        .out_a(out_a), .out_b(out_b), .stall_cnt(stall_cnt)
    );

    // Register file: Rn = n*0x11 out of reset, posedge write
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'(i * 17);
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end
    assign r_data1 = regs[r_addr1];
    assign r_data2 = regs[r_addr2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [3:0] rd, input logic wr);
        in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr = wr;
    endtask

    task automatic wb(input logic we, input logic [3:0] a, input logic [15:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        wb(1'b0, 4'h0, 16'h0);
        tick(); tick();
        in_valid = 1'b1; #1;
        chk("rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst = 1'b0; tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_busy", dut.u_sb.busy_q, 0);

        // Back-to-back independent issue
        drive(1'b1, 4'h5, 4'h1, 4'h2, 4'h3, 1'b1); #1;
        chk("b2b_ready0", in_ready, 1);
        chk("b2b_raddr1", r_addr1, 1);
        chk("b2b_raddr2", r_addr2, 2);
        tick();
        drive(1'b1, 4'h6, 4'h4, 4'h5, 4'h6, 1'b1); #1;
        chk("b2b_ready1", in_ready, 1);
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_a0", out_a, 16'h0011);
        chk("b2b_b0", out_b, 16'h0022);
        chk("b2b_op0", {out_op, out_rd, 3'b0, out_wr}, {4'h5, 4'h3, 4'h1});
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("b2b_a1", out_a, 16'h0044);
        chk("b2b_b1", out_b, 16'h0055);
        chk("b2b_rd1", out_rd, 6);
        chk("b2b_busy", dut.u_sb.busy_q, 16'h0048);
        tick();
        chk("drain_valid", out_valid, 0);

        // RAW stall on R3, released by writeback in the same cycle
        drive(1'b1, 4'h7, 4'h3, 4'h0, 4'h8, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1 chk("raw_stall", in_ready, 0);
            tick();
        end
        chk("raw_cnt", stall_cnt, 3);
        wb(1'b1, 4'h3, 16'hBEEF); #1;
        chk("raw_release", in_ready, 1);
        tick();
        wb(1'b0, 4'h0, 16'h0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("raw_fwd_a", out_a, 16'hBEEF);
        chk("raw_busy", dut.u_sb.busy_q, 16'h0140);
        chk("raw_cnt_hold", stall_cnt, 3);

        // WAW on R7: stalls until writeback, set beats the simultaneous clear
        drive(1'b1, 4'h1, 4'h0, 4'h0, 4'h7, 1'b1); tick();
        drive(1'b1, 4'h2, 4'h0, 4'h0, 4'h7, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1 chk("waw_stall", in_ready, 0);
            tick();
        end
        wb(1'b1, 4'h7, 16'h7777); #1;
        chk("waw_release", in_ready, 1);
        tick();
        wb(1'b0, 4'h0, 16'h0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("waw_op", out_op, 2);
        chk("waw_busy", dut.u_sb.busy_q, 16'h01C0);
        tick();

        // Backpressure: held bundle stays stable, pending instr waits
        drive(1'b1, 4'h9, 4'h1, 4'h2, 4'hA, 1'b0); tick();
        out_ready = 1'b0;
        drive(1'b1, 4'hA, 4'h4, 4'h5, 4'hB, 1'b0);
        wb(1'b1, 4'h1, 16'h5555);     // write to non-busy R1 must not disturb out_a
        for (int c = 0; c < 4; c++) begin
            #1 chk("bp_ready", in_ready, 0);
            chk("bp_stable", {out_valid, out_op, out_a}, {1'b1, 4'h9, 16'h0011});
            tick();
            wb(1'b0, 4'h0, 16'h0);
        end
        chk("bp_cnt", stall_cnt, 9);
        chk("bp_busy", dut.u_sb.busy_q, 16'h01C0);
        out_ready = 1'b1; #1;
        chk("bp_release", in_ready, 1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("bp_new_op", {out_op, out_a}, {4'hA, 16'h0044});
        tick();

        // Flush: drop held rd=9 bundle, concurrent writeback to R6
        out_ready = 1'b0;
        drive(1'b1, 4'h3, 4'h0, 4'h0, 4'h9, 1'b1); tick();
        chk("fl_held", {out_valid, out_rd}, {1'b1, 4'h9});
        drive(1'b1, 4'h4, 4'h1, 4'h1, 4'hB, 1'b1);
        flush = 1'b1;
        wb(1'b1, 4'h6, 16'h6666); #1;
        chk("fl_no_issue", in_ready, 0);
        tick();
        flush = 1'b0;
        wb(1'b0, 4'h0, 16'h0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("fl_valid", out_valid, 0);
        chk("fl_busy", dut.u_sb.busy_q, 16'h0180);
        chk("fl_cnt", stall_cnt, 10);

        // Reset mid-stream with valid bundle and busy bits held
        out_ready = 1'b0;
        drive(1'b1, 4'h5, 4'h0, 4'h0, 4'h4, 1'b1); tick();
        chk("mr_setup", {out_valid, dut.u_sb.busy_q}, {1'b1, 16'h0190});
        rst = 1'b1; #1;
        chk("mr_in_ready", in_ready, 0);
        tick();
        chk("mr_state", {out_valid, stall_cnt, dut.u_sb.busy_q}, 33'h0);
        chk("mr_out", {out_op, out_rd, out_wr, out_a, out_b}, 0);
        rst = 1'b0; out_ready = 1'b1;
        drive(1'b1, 4'h6, 4'h7, 4'h8, 4'h4, 1'b1); #1;
        chk("mr_post_ready", in_ready, 1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("mr_post_a", {out_a, out_b}, {16'h0077, 16'h0088});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting between the decoder and the execute stage. Drives the register file's two read-address ports, and bypasses a same-cycle writeback because the register file's posedge write is not visible to a same-cycle read. Holds a 16-entry busy scoreboard to stall RAW/WAW hazards, and presents one registered operand bundle to execute over a valid/ready handshake.

## Interface
- DATA_W, 16, register/operand width
- ADDR_W, 4, register address width (16 registers, all general-purpose, no hard-wired zero)
- OP_W, 4, opcode width (passed through, not interpreted)

- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  OP_W  opcode
- in_rs1, in_rs2  in  ADDR_W  source registers
- in_rd  in  ADDR_W  destination register
- in_wr  in  1  instruction writes in_rd
- r_addr1, r_addr2  out  ADDR_W  register-file read addresses
- r_data1, r_data2  in  DATA_W  register-file read data, combinational
- wb_we, wb_addr, wb_data  in  1/ADDR_W/DATA_W  copy of the register-file write port
- flush  in  1  discard the held output bundle
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts bundle
- out_op, out_rd, out_wr  out  OP_W/ADDR_W/1  registered pass-through
- out_a, out_b  out  DATA_W  operands for rs1/rs2
- stall_cnt  out  16  saturating count of cycles with in_valid && !in_ready

## Operation
- r_addr1 = in_rs1, r_addr2 = in_rs2, combinational at all times.
- Forwarding: operand X = wb_data if wb_we && wb_addr == in_rsX, else r_dataX.
- Scoreboard: busy[15:0].
  - clr[i] = wb_we && wb_addr == i.
  - eff_busy = busy & ~clr.
- Hazard: eff_busy[in_rs1] || eff_busy[in_rs2] || (in_wr && eff_busy[in_rd]).
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready). May depend combinationally on the in_* fields.
- Issue = in_valid && in_ready. On issue:
  - Load the output register with op, rd, wr and the forwarded operands.
  - out_valid <= 1.
  - If in_wr, set busy[in_rd].
- Set and clear of the same bit in one cycle: set wins.
- Handshake: if out_valid && out_ready && no issue, then out_valid <= 0. Output fields hold stable while out_valid && !out_ready.
- flush: out_valid <= 0. If out_valid && out_wr, clear busy[out_rd]. A flush in the same cycle as a writeback to a different register applies both clears. No issue occurs in a flush cycle.
- Writeback to a non-busy register is legal; data is still forwarded and busy stays 0.
- stall_cnt increments on in_valid && !in_ready and saturates at 0xFFFF.
- Reset: out_valid=0, out_op/out_rd/out_wr/out_a/out_b=0, busy=0, stall_cnt=0. in_ready=0 while rst is high. Reset mid-operation discards the held bundle and all scoreboard state.

## Timing
- Accept-to-out_valid latency: 1 cycle.
- Throughput: 1 instruction/cycle when hazard-free and out_ready=1.
- Stall release: a stalled consumer is accepted in the same cycle its producer's wb_we is asserted (via forwarding), not one cycle later.
- No combinational path from out_ready to out_* data; in_ready does depend combinationally on out_ready.
- r_dataX is sampled only in the issue cycle.

## Structure
- Shared package holds DATA_W, ADDR_W, OP_W, NREGS=16 and the output bundle struct/typedef. The decoder and execute stage import the same package.
- One sub-module: reg_scoreboard, holding the busy vector, set/clear/flush-clear logic and the eff_busy output.
- Forwarding muxes, the output register and stall_cnt live in operand_fetch.

## Test plan
- Back-to-back independent: issue (rs1=1, rs2=2, rd=3, wr), then (rs1=4, rs2=5, rd=6, wr), out_ready=1, reg file R1=0x0011, R2=0x0022 -> in_ready stays 1; first bundle appears next cycle with out_a=0x0011, out_b=0x0022; busy[3] and busy[6] set.
- RAW stall and release: issue rd=3 wr; next instruction has rs1=3. Hold wb_we=0 for 3 cycles -> in_ready=0, stall_cnt=3. Then wb_we=1, wb_addr=3, wb_data=0xBEEF -> accepted that cycle, out_a=0xBEEF next cycle, busy[3]=0.
- WAW: busy[7] set, new instruction with rd=7 wr=1 and sources 0/0 -> stalls until writeback to R7; after issue busy[7]=1 (set wins over the simultaneous clear).
- Backpressure: out_valid=1, out_ready=0 for 4 cycles -> out_* stable, in_ready=0. Raise out_ready -> the pending input is issued in that cycle.
- Flush: held bundle rd=9 wr=1, flush=1 -> out_valid=0 next cycle, busy[9]=0, no issue in that cycle.
- Reset mid-stream: assert rst with out_valid=1, busy=0x00F0, stall_cnt=5 -> all three read 0 after one clock; in_ready=0 while rst=1.
